instr_fetch: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and issues one-outstanding-request reads to instruction memory. It holds the IF/ID pipeline register that drives `instr` and `pc` into the decode stage. It accepts decode-stage stalls and branch/jump redirects, and discards in-flight responses that a redirect makes stale.

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads to instruction memory
// and holds the IF/ID register. Handles decode stalls, redirects and stale-response discard.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instrValid
);

    localparam logic [1:0] StFetch   = 2'd0;
    localparam logic [1:0] StWait    = 2'd1;
    localparam logic [1:0] StHold    = 2'd2;
    localparam logic [1:0] StDiscard = 2'd3;

    logic [1:0]  state, stateNext;
    logic [31:0] fetchPc, fetchPcNext, fetchPcPlus4;
    logic [31:0] bufInstr, bufInstrNext, bufPc, bufPcNext;
    logic [31:0] instrNext, pcNext, pcPlus4Next;
    logic        instrValidNext;

    assign fetchPcPlus4 = fetchPc + 32'd4;

    // Request path is combinational so an accepted response can issue the next fetch same cycle.
    always_comb begin
        imemReq  = 1'b0;
        imemAddr = fetchPc;
        if (rst_n && !redirect) begin
            case (state)
                StFetch: imemReq = 1'b1;
                StWait: begin
                    if (imemValid && !stall) begin
                        imemReq  = 1'b1;
                        imemAddr = fetchPcPlus4;
                    end
                end
                default: imemReq = 1'b0;
            endcase
        end
    end

    always_comb begin
        stateNext      = state;
        fetchPcNext    = fetchPc;
        bufInstrNext   = bufInstr;
        bufPcNext      = bufPc;
        instrNext      = instr;
        pcNext         = pc;
        pcPlus4Next    = pcPlus4;
        instrValidNext = instrValid;

        if (redirect) begin
            fetchPcNext    = redirectPc & 32'hFFFF_FFFC;
            instrNext      = 32'd0;
            instrValidNext = 1'b0;
            bufInstrNext   = 32'd0;
            bufPcNext      = 32'd0;
            // An outstanding request whose response has not arrived must still be drained.
            if ((state == StWait || state == StDiscard) && !imemValid) begin
                stateNext = StDiscard;
            end else begin
                stateNext = StFetch;
            end
        end else begin
            if (!stall) begin
                instrNext      = 32'd0;
                instrValidNext = 1'b0;
            end
            case (state)
                StFetch: stateNext = StWait;
                StWait: begin
                    if (imemValid && !stall) begin
                        instrNext      = imemData;
                        pcNext         = fetchPc;
                        pcPlus4Next    = fetchPcPlus4;
                        instrValidNext = 1'b1;
                        fetchPcNext    = fetchPcPlus4;
                    end else if (imemValid) begin
                        bufInstrNext = imemData;
                        bufPcNext    = fetchPc;
                        stateNext    = StHold;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        instrNext      = bufInstr;
                        pcNext         = bufPc;
                        pcPlus4Next    = bufPc + 32'd4;
                        instrValidNext = 1'b1;
                        fetchPcNext    = fetchPcPlus4;
                        stateNext      = StFetch;
                    end
                end
                default: begin
                    if (imemValid) begin
                        stateNext = StFetch;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StFetch;
            fetchPc    <= RESET_PC;
            bufInstr   <= 32'd0;
            bufPc      <= 32'd0;
            instr      <= 32'd0;
            pc         <= 32'd0;
            pcPlus4    <= 32'd0;
            instrValid <= 1'b0;
        end else begin
            state      <= stateNext;
            fetchPc    <= fetchPcNext;
            bufInstr   <= bufInstrNext;
            bufPc      <= bufPcNext;
            instr      <= instrNext;
            pc         <= pcNext;
            pcPlus4    <= pcPlus4Next;
            instrValid <= instrValidNext;
        end
    end

endmodule
